// File: rtl/ppl_fb_writer.sv
// Framebuffer writer at the tail of the ray-cast pipeline: texel fetch, pixel FIFO and
// valid/ready framebuffer write port with drop accounting and end-of-frame pulse.
module ppl_fb_writer #(
    parameter int unsigned H_DISP     = 1280,
    parameter int unsigned V_DISP     = 720,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned COLOR_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [19:0]                   in_pixel_addr,
    input  logic [12:0]                   in_texture_addr,
    output logic [12:0]                   tex_addr,
    input  logic [COLOR_W-1:0]            tex_data,
    output logic                          fb_wr_en,
    output logic [19:0]                   fb_wr_addr,
    output logic [COLOR_W-1:0]            fb_wr_data,
    input  logic                          fb_wr_ready,
    input  logic                          ovf_clr,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned NumPix   = H_DISP * V_DISP;
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam logic [19:0] LastAddr = 20'(NumPix - 1);
    localparam logic [PtrW:0] FullLvl = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e               state_q, state_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [19:0]          s1_pix_q, s1_pix_d;
    logic [12:0]          tex_addr_q, tex_addr_d;
    logic                 s2_valid_q;
    logic [19:0]          s2_pix_q;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]        level_q, level_d;
    logic [19:0]          wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0]   wr_data_q, wr_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic [19:0]          mem_addr [FIFO_DEPTH];
    logic [COLOR_W-1:0]   mem_data [FIFO_DEPTH];

    logic in_range, range_drop, slot_free, fifo_empty, fifo_full;
    logic pop, push, bypass, fifo_drop, fire;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        in_range   = ({12'd0, in_pixel_addr} < NumPix);
        range_drop = in_valid && !in_range;
        s1_valid_d = in_valid && in_range;
        s1_pix_d   = s1_valid_d ? in_pixel_addr : s1_pix_q;
        tex_addr_d = s1_valid_d ? in_texture_addr : tex_addr_q;

        // The output slot frees when idle or when the pending write transfers this cycle.
        // An empty FIFO lets stage 2 load the slot directly, giving the N+3 first write.
        slot_free  = (state_q == StIdle) || fb_wr_ready;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == FullLvl);
        fire       = (state_q == StPend) && fb_wr_ready;
        pop        = slot_free && !fifo_empty;
        bypass     = slot_free && fifo_empty && s2_valid_q;
        push       = s2_valid_q && !bypass && (!fifo_full || pop);
        fifo_drop  = s2_valid_q && !bypass && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + (PtrW + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (PtrW + 1)'(1);
        end

        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle, StPend: begin
                if (pop) begin
                    state_d   = StPend;
                    wr_addr_d = mem_addr[rd_ptr_q];
                    wr_data_d = mem_data[rd_ptr_q];
                end else if (bypass) begin
                    state_d   = StPend;
                    wr_addr_d = s2_pix_q;
                    wr_data_d = tex_data;
                end else if (fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        frame_done_d = fire && (wr_addr_q == LastAddr);

        drop_inc = {1'b0, range_drop} + {1'b0, fifo_drop};
        drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
        if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            overflow_d = overflow_q || range_drop || fifo_drop;
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            tex_addr_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_pix_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            s1_valid_q   <= s1_valid_d;
            s1_pix_q     <= s1_pix_d;
            tex_addr_q   <= tex_addr_d;
            s2_valid_q   <= s1_valid_q;
            s2_pix_q     <= s1_pix_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= s2_pix_q;
            mem_data[wr_ptr_q] <= tex_data;
        end
    end

    assign tex_addr   = tex_addr_q;
    assign fb_wr_en   = (state_q == StPend);
    assign fb_wr_addr = wr_addr_q;
    assign fb_wr_data = wr_data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_ppl_fb_writer.sv
// Directed bench for ppl_fb_writer: latency, backpressure/drops, streaming, frame end,
// range drop with clear, and mid-operation reset.
module tb_ppl_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_pixel_addr;
    logic [12:0] in_texture_addr;
    logic [12:0] tex_addr;
    logic [15:0] tex_data = '0;
    logic        fb_wr_en;
    logic [19:0] fb_wr_addr;
    logic [15:0] fb_wr_data;
    logic        fb_wr_ready;
    logic        ovf_clr;
    logic        frame_done;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [4:0]  fifo_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int frame_cnt = 0;
    int max_lvl  = 0;
    logic [19:0] got_addr[$];
    logic [15:0] got_data[$];
    int          got_cyc[$];

    ppl_fb_writer dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_pixel_addr   (in_pixel_addr),
        .in_texture_addr (in_texture_addr),
        .tex_addr        (tex_addr),
        .tex_data        (tex_data),
        .fb_wr_en        (fb_wr_en),
        .fb_wr_addr      (fb_wr_addr),
        .fb_wr_data      (fb_wr_data),
        .fb_wr_ready     (fb_wr_ready),
        .ovf_clr         (ovf_clr),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .drop_cnt        (drop_cnt),
        .fifo_level      (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [12:0] a);
        if (a == 13'd9) return 16'hABCD;
        return ({3'b0, a} * 16'd37) ^ 16'h1234;
    endfunction

    always @(posedge clk) tex_data <= rom_f(tex_addr);
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_wr_en && fb_wr_ready) begin
            got_addr.push_back(fb_wr_addr);
            got_data.push_back(fb_wr_data);
            got_cyc.push_back(cyc);
        end
        if (frame_done) frame_cnt++;
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [19:0] a, input logic [12:0] t);
        in_valid        = 1'b1;
        in_pixel_addr   = a;
        in_texture_addr = t;
        tick();
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pixel_addr = '0; in_texture_addr = '0;
        fb_wr_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        check("rst_wr_en", 32'(fb_wr_en), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_frame", 32'(frame_done), 32'd0);
        check("rst_tex_addr", 32'(tex_addr), 32'd0);
        rst = 1'b0;
        tick();

        // T1: first write appears three cycles after the input strobe
        fb_wr_ready = 1'b1;
        send(20'd5, 13'd9);
        in_valid = 1'b0;
        check("t1_tex_addr", 32'(tex_addr), 32'd9);
        check("t1_en_c1", 32'(fb_wr_en), 32'd0);
        tick();
        check("t1_en_c2", 32'(fb_wr_en), 32'd0);
        tick();
        check("t1_en_c3", 32'(fb_wr_en), 32'd1);
        check("t1_addr", 32'(fb_wr_addr), 32'd5);
        check("t1_data", 32'(fb_wr_data), 32'hABCD);
        tick();
        check("t1_en_c4", 32'(fb_wr_en), 32'd0);
        repeat (5) tick();
        check("t1_write_count", 32'(got_addr.size()), 32'd1);

        // T2: stall; one pixel waits in the output slot, 16 fill the FIFO, the last 2 drop
        clear_log();
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 19; i++) send(20'(100 + i), 13'(200 + i));
        in_valid = 1'b0;
        check("t2_addr_early", 32'(fb_wr_addr), 32'd100);
        repeat (11) tick();
        check("t2_level", 32'(fifo_level), 32'd16);
        check("t2_drop", 32'(drop_cnt), 32'd2);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_en", 32'(fb_wr_en), 32'd1);
        check("t2_addr_hold", 32'(fb_wr_addr), 32'd100);
        check("t2_data_hold", 32'(fb_wr_data), 32'(rom_f(13'd200)));
        fb_wr_ready = 1'b1;
        repeat (25) tick();
        check("t2_write_count", 32'(got_addr.size()), 32'd17);
        for (int i = 0; i < 17 && i < got_addr.size(); i++) begin
            check("t2_order_addr", 32'(got_addr[i]), 32'(100 + i));
            check("t2_order_data", 32'(got_data[i]), 32'(rom_f(13'(200 + i))));
        end
        check("t2_level_end", 32'(fifo_level), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t2_clr_ovf", 32'(overflow), 32'd0);
        check("t2_clr_drop", 32'(drop_cnt), 32'd0);

        // T3: continuous stream at one pixel per cycle
        clear_log();
        max_lvl = 0;
        for (int i = 0; i < 100; i++) send(20'(1000 + i), 13'(i));
        in_valid = 1'b0;
        repeat (6) tick();
        check("t3_write_count", 32'(got_addr.size()), 32'd100);
        if (got_cyc.size() == 100)
            check("t3_back_to_back", 32'(got_cyc[99] - got_cyc[0]), 32'd99);
        for (int i = 0; i < 100 && i < got_addr.size(); i++) begin
            check("t3_addr", 32'(got_addr[i]), 32'(1000 + i));
            check("t3_data", 32'(got_data[i]), 32'(rom_f(13'(i))));
        end
        check("t3_max_level_le2", 32'(max_lvl <= 2), 32'd1);
        check("t3_drop", 32'(drop_cnt), 32'd0);

        // T4: last pixel of the frame with ready held off for 3 cycles
        clear_log();
        frame_cnt = 0;
        fb_wr_ready = 1'b0;
        send(20'd921599, 13'd50);
        in_valid = 1'b0;
        tick();
        tick();
        check("t4_en", 32'(fb_wr_en), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_pulse_pending", 32'(frame_done), 32'd0);
        end
        fb_wr_ready = 1'b1;
        tick();
        check("t4_pulse", 32'(frame_done), 32'd1);
        check("t4_en_after", 32'(fb_wr_en), 32'd0);
        tick();
        check("t4_pulse_end", 32'(frame_done), 32'd0);
        check("t4_pulse_count", 32'(frame_cnt), 32'd1);
        check("t4_write_count", 32'(got_addr.size()), 32'd1);

        // T5: out-of-range address is dropped, then cleared
        clear_log();
        send(20'd921600, 13'd1);
        in_valid = 1'b0;
        check("t5_drop", 32'(drop_cnt), 32'd1);
        check("t5_ovf", 32'(overflow), 32'd1);
        repeat (5) tick();
        check("t5_no_write", 32'(got_addr.size()), 32'd0);
        check("t5_level", 32'(fifo_level), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr_ovf", 32'(overflow), 32'd0);
        check("t5_clr_drop", 32'(drop_cnt), 32'd0);

        // T6: reset with 8 buffered entries and a pending write
        clear_log();
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(20'(2000 + i), 13'(300 + i));
        in_valid = 1'b0;
        repeat (3) tick();
        check("t6_level_pre", 32'(fifo_level), 32'd8);
        check("t6_en_pre", 32'(fb_wr_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_en_post", 32'(fb_wr_en), 32'd0);
        check("t6_level_post", 32'(fifo_level), 32'd0);
        fb_wr_ready = 1'b1;
        repeat (10) tick();
        check("t6_no_stale", 32'(got_addr.size()), 32'd0);
        check("t6_en_idle", 32'(fb_wr_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
